// File: rtl/sram_bank.sv
// sram_bank: single-port synchronous SRAM bank with a one-cycle registered read,
// optional per-byte write masking and an active-low chip select. Either a flop
// register array or a behavioural stand-in for the technology macro is built.

package sram_type_pkg;
  typedef enum logic [1:0] {TECH_FDSOI, TECH_BULK, TECH_FINFET} tech_e;
  typedef enum logic [0:0] {TYPE1_RA, TYPE1_RF} type1_e;
  typedef enum logic [0:0] {TYPE2_HD, TYPE2_HS} type2_e;
  typedef enum logic [1:0] {VTH_L, VTH_R, VTH_S} vth_e;
  typedef enum logic [0:0] {WMASK_DISABLE, WMASK_ENABLE} wmask_e;
endpackage

module sram_bank
  import sram_type_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned DEPTH       = 256,
  parameter tech_e       TECH        = TECH_FDSOI,
  parameter type1_e      TYPE1       = TYPE1_RA,
  parameter type2_e      TYPE2       = TYPE2_HD,
  parameter vth_e        VTH         = VTH_L,
  parameter wmask_e      WMASK_EN    = WMASK_DISABLE,
  parameter bit          REG_MEM_USE = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        resetn_i,
  input  logic                        csn_i,
  input  logic                        we_i,
  input  logic [$clog2(DEPTH)-1:0]    addr_i,
  input  logic [DATA_WIDTH/8-1:0]     be_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  output logic [DATA_WIDTH-1:0]       rdata_o
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  // Elaboration-time guards on the geometry and on the macro flavour codes.
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH == 0 || DEPTH < 2) begin : g_bad_geometry
    $error("sram_bank: DATA_WIDTH must be a non-zero multiple of 8 and DEPTH >= 2");
  end
  if (int'(TECH) > int'(TECH_FINFET) || int'(TYPE1) > int'(TYPE1_RF) ||
      int'(TYPE2) > int'(TYPE2_HS) || int'(VTH) > int'(VTH_S)) begin : g_bad_flavour
    $error("sram_bank: unknown macro flavour selection");
  end

  // Addresses beyond DEPTH only exist for non-power-of-two depths.
  logic                  addr_ok;
  logic                  wr_en;
  logic                  rd_en;
  logic [NBYTES-1:0]     wr_mask;
  logic [DATA_WIDTH-1:0] rd_word;

  assign addr_ok = (32'(addr_i) < DEPTH);
  // Writes are blocked while reset is asserted and dropped when out of range.
  assign wr_en   = resetn_i & ~csn_i & we_i & addr_ok;
  assign rd_en   = ~csn_i & ~we_i;
  // Without masking every byte lane is written regardless of be_i.
  assign wr_mask = (WMASK_EN == WMASK_ENABLE) ? be_i : {NBYTES{1'b1}};

  if (REG_MEM_USE) begin : g_reg_mem
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane writes into the flop array; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
      if (wr_en) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (wr_mask[b]) begin
            mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end

    assign rd_word = addr_ok ? mem[addr_i] : '0;
  end else begin : g_macro
    // Behavioural stand-in for the hard macro: a bit-masked word write,
    // which is how the macro's write port presents byte enables.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] bit_mask;

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bmask
      assign bit_mask[8*gi +: 8] = {8{wr_mask[gi]}};
    end

    // Masked full-word write into the macro model.
    always_ff @(posedge clk_i) begin
      if (wr_en) begin
        mem[addr_i] <= (mem[addr_i] & ~bit_mask) | (wdata_i & bit_mask);
      end
    end

    assign rd_word = addr_ok ? mem[addr_i] : '0;
  end

  // Output register: loaded only by reads, held otherwise, cleared by reset.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rdata_o <= '0;
    end else if (rd_en) begin
      rdata_o <= rd_word;
    end
  end

endmodule

// File: tb/tb_sram_bank.sv
// Scoreboard bench for sram_bank: two instances (byte mask enabled on the flop
// array, mask disabled on the macro stand-in) share stimulus; a reference model
// predicts rdata_o after every edge and a monitor compares on the falling edge.

module tb_sram_bank;
  import sram_type_pkg::*;

  localparam int DW = 32;
  localparam int DP = 16;
  localparam int AW = 4;
  localparam int BW = 4;

  logic          clk;
  logic          resetn;
  logic          csn;
  logic          we;
  logic [AW-1:0] addr;
  logic [BW-1:0] be;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata_m;
  logic [DW-1:0] rdata_f;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] exp_m;
    logic [DW-1:0] exp_f;
    string         tag;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: word arrays plus the value each output should show.
  logic [DW-1:0] ref_m [DP];
  logic [DW-1:0] ref_f [DP];
  logic [DW-1:0] out_m;
  logic [DW-1:0] out_f;

  sram_bank #(
    .DATA_WIDTH(DW), .DEPTH(DP), .WMASK_EN(WMASK_ENABLE), .REG_MEM_USE(1'b1)
  ) dut_m (
    .clk_i(clk), .resetn_i(resetn), .csn_i(csn), .we_i(we), .addr_i(addr),
    .be_i(be), .wdata_i(wdata), .rdata_o(rdata_m)
  );

  sram_bank #(
    .DATA_WIDTH(DW), .DEPTH(DP), .WMASK_EN(WMASK_DISABLE), .REG_MEM_USE(1'b0)
  ) dut_f (
    .clk_i(clk), .resetn_i(resetn), .csn_i(csn), .we_i(we), .addr_i(addr),
    .be_i(be), .wdata_i(wdata), .rdata_o(rdata_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [DW-1:0] got_m,
                       input logic [DW-1:0] want_m, input logic [DW-1:0] got_f,
                       input logic [DW-1:0] want_f);
    n_vec++;
    if (got_m !== want_m || got_f !== want_f) begin
      n_err++;
      $display("FAIL %s: mask got %h want %h | full got %h want %h",
               tag, got_m, want_m, got_f, want_f);
    end else begin
      $display("ok   %s: mask %h full %h", tag, got_m, got_f);
    end
  endtask

  // One clock cycle of stimulus; the model predicts the post-edge output.
  task automatic cyc(input logic c, input logic w, input logic [AW-1:0] a,
                     input logic [BW-1:0] b, input logic [DW-1:0] d, input string tag);
    exp_t e;
    csn = c; we = w; addr = a; be = b; wdata = d;
    @(posedge clk);
    if (resetn && !c) begin
      if (w) begin
        ref_f[a] = d;
        for (int k = 0; k < BW; k++)
          if (b[k]) ref_m[a][8*k +: 8] = d[8*k +: 8];
      end else begin
        out_m = ref_m[a];
        out_f = ref_f[a];
      end
    end
    if (!resetn) begin
      out_m = '0;
      out_f = '0;
    end
    e.exp_m = out_m;
    e.exp_f = out_f;
    e.tag   = tag;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every falling edge, compare the DUT outputs with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, rdata_m, e.exp_m, rdata_f, e.exp_f);
      end
    end
  end

  initial begin
    resetn = 1'b0; csn = 1'b1; we = 1'b0; addr = '0; be = '0; wdata = '0;
    out_m = '0; out_f = '0;
    #2;
    check("reset_value", rdata_m, '0, rdata_f, '0);
    @(negedge clk);
    resetn = 1'b1;

    // Idle with random inputs: output stays at zero.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'($urandom), 4'($urandom), 4'($urandom), $urandom, "idle_random");

    // Give every word a known value.
    for (int i = 0; i < DP; i++)
      cyc(1'b0, 1'b1, 4'(i), 4'hF, $urandom, "init_write");

    cyc(1'b0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF, "wr3");
    cyc(1'b0, 1'b1, 4'd4, 4'hF, 32'h12345678, "wr4");
    cyc(1'b0, 1'b0, 4'd3, 4'h0, 32'h0, "rd3_deadbeef");
    cyc(1'b0, 1'b0, 4'd4, 4'h0, 32'h0, "rd4_12345678");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 4'($urandom), 4'($urandom), $urandom, "hold_12345678");

    // Asynchronous reset pulse between edges.
    #2 resetn = 1'b0;
    #1 check("async_reset_clear", rdata_m, '0, rdata_f, '0);
    out_m = '0; out_f = '0;
    #1 resetn = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, "post_reset_idle");
    cyc(1'b0, 1'b0, 4'd4, 4'h0, 32'h0, "post_reset_rd4");

    // Byte masking: mask instance merges, full instance takes the whole word.
    cyc(1'b0, 1'b1, 4'd5, 4'hF, 32'hAABBCCDD, "wr5_full");
    cyc(1'b0, 1'b1, 4'd5, 4'h5, 32'h11223344, "wr5_be5");
    cyc(1'b0, 1'b0, 4'd5, 4'h0, 32'h0, "rd5_be5");
    cyc(1'b0, 1'b1, 4'd5, 4'hF, 32'hAABBCCDD, "wr5_full2");
    cyc(1'b0, 1'b1, 4'd5, 4'h1, 32'h11223344, "wr5_be1");
    cyc(1'b0, 1'b0, 4'd5, 4'hF, 32'h0, "rd5_be1");

    // A write leaves the output register untouched.
    cyc(1'b0, 1'b0, 4'd3, 4'h0, 32'h0, "rd3_again");
    cyc(1'b0, 1'b1, 4'd3, 4'hF, 32'h0, "wr3_zero_hold");
    cyc(1'b1, 1'b0, 4'd3, 4'h0, 32'h0, "idle_hold");
    cyc(1'b0, 1'b0, 4'd3, 4'h0, 32'h0, "rd3_zero");

    // A write attempted while reset is held across an edge is blocked.
    resetn = 1'b0;
    out_m = '0; out_f = '0;
    cyc(1'b0, 1'b1, 4'd6, 4'hF, 32'hCAFEF00D, "wr6_in_reset");
    resetn = 1'b1;
    cyc(1'b0, 1'b0, 4'd6, 4'h0, 32'h0, "rd6_unchanged");

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom),
          4'($urandom), $urandom, "random");

    // Idle noise must not change contents; read everything back.
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'($urandom), 4'($urandom), 4'($urandom), $urandom, "idle_noise");
    for (int i = 0; i < DP; i++)
      cyc(1'b0, 1'b0, 4'(i), 4'($urandom), $urandom, "final_readback");

    @(negedge clk);
    #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_bank.md
# sram_bank

Single-port synchronous SRAM bank with one-cycle registered read data, per-byte write enables and an active-low chip select. It is the leaf storage element that `tcdm_mem` tiles vertically (depth) and horizontally (width) to build a TCDM bank. Technology parameters select the hard macro flavour; `REG_MEM_USE` selects a flop-based register-array implementation instead.

## Interface
Parameters:
- `DATA_WIDTH`, 256: word width in bits; multiple of 8.
- `DEPTH`, 256: number of words; ≥ 2.
- `TECH`, `TECH_FDSOI` (`sram_type_pkg::tech_e`): macro technology selection.
- `TYPE1`, `TYPE1_RA` (`type1_e`): macro type selection.
- `TYPE2`, `TYPE2_HD` (`type2_e`): macro density selection.
- `VTH`, `VTH_L` (`vth_e`): macro threshold flavour.
- `WMASK_EN`, `WMASK_DISABLE` (`wmask_e`): enables per-byte write masking.
- `REG_MEM_USE`, 1: 1 = flop register array; 0 = technology macro wrapper.

Ports:
- `clk_i` in 1: clock, rising edge.
- `resetn_i` in 1: reset, asynchronous, active-low.
- `csn_i` in 1: chip select, active-low.
- `we_i` in 1: 1 = write, 0 = read. Sampled only when `csn_i`=0.
- `addr_i` in `$clog2(DEPTH)`: word address.
- `be_i` in `DATA_WIDTH/8`: byte enables. Bit k covers `wdata_i[8k+7:8k]`.
- `wdata_i` in `DATA_WIDTH`: write data.
- `rdata_o` out `DATA_WIDTH`: registered read data.

## Operation
- Idle: `csn_i`=1. No array access. `rdata_o` holds its value.
- Write: `csn_i`=0 and `we_i`=1 at a rising edge.
  - `WMASK_EN`=`WMASK_ENABLE`: only bytes with `be_i[k]`=1 are updated; all other bytes keep their contents.
  - `WMASK_EN`=`WMASK_DISABLE`: `be_i` is ignored and the full word is written.
  - A write does not change `rdata_o`.
- Read: `csn_i`=0 and `we_i`=0 at a rising edge. `mem[addr_i]` is loaded into the output register. `be_i` is ignored.
- `rdata_o` holds the last read word until the next read or a reset. A consumer that stalls may sample it in later cycles.
- Out-of-range address (`addr_i` ≥ `DEPTH`, possible only when `DEPTH` is not a power of two):
  - write is dropped;
  - read loads all zeros.
- `REG_MEM_USE`=0: the technology parameters select the macro. The externally visible behaviour is identical to `REG_MEM_USE`=1, and a behavioural model with the same semantics is an acceptable macro stand-in.
- Array contents are not reset. Contents are undefined until written.

## Timing
- Read latency is 1 cycle. Read at edge N → data valid on `rdata_o` after edge N, stable through edge N+1 and beyond.
- Write takes effect at the edge. A read of the same address at edge N+1 returns the new data.
- Back-to-back reads are supported every cycle, giving one new word per cycle.
- Reset: when `resetn_i`=0, `rdata_o` is asynchronously cleared to 0 and array writes are blocked.
- Reset deasserting mid-sequence: the first edge with `resetn_i`=1 performs a normal access.

## Test plan
- Reset then idle: `rdata_o`=0. With `csn_i`=1 and random `we_i`/`addr_i`/`wdata_i`, `rdata_o` stays 0 and no array content changes.
- Full write/read, DATA_WIDTH=32, DEPTH=16:
  - write 0xDEADBEEF to addr 3, write 0x12345678 to addr 4;
  - read addr 3 → 0xDEADBEEF one cycle later;
  - read addr 4 next cycle → 0x12345678;
  - `rdata_o` holds 0x12345678 through 3 idle cycles.
- Byte mask, `WMASK_ENABLE`: write 0xAABBCCDD to addr 5 with be=0xF, then write 0x11223344 with be=0x5. Read addr 5 → 0xAA22CC44.
- Mask disabled, `WMASK_DISABLE`: write 0xAABBCCDD with be=0xF, then write 0x11223344 with be=0x1. Read → 0x11223344.
- Write does not disturb output: read addr 3 (0xDEADBEEF), then write 0x0 to addr 3. `rdata_o` remains 0xDEADBEEF. Re-read addr 3 → 0x0.
- Async reset mid-operation: after a read returns 0x12345678, pulse `resetn_i` low between edges. `rdata_o`=0 immediately. After reset, read addr 4 → 0x12345678, since contents are retained.
